serial_program_loader: RTL and testbench
========================================

// Module: serial_program_loader
// PURPOSE
//  Boot-time writer for the processor's 13-bit x 16-bit instruction memory: receives a program image
//  over an asynchronous serial line (8N1), writes it word by word into instruction memory from address 0,
//  then asserts start so the processor fetches from the loaded image. After the processor raises hlt,
//  the loader drops start and re-arms for a new image. Sits between the board serial pin and the
//  instruction-memory write port / processor start input.
// PARAMETERS
//  CLKS_PER_BIT  16    clk cycles per serial bit; even, >= 4
//  ADDR_W        13    instruction-memory address width
//  MAX_WORDS     8192  largest accepted image, in words (<= 2**ADDR_W)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low
//  rx         in   1       serial input, idle high, asynchronous to clk
//  hlt        in   1       processor halted
//  mem_we     out  1       instruction-memory write strobe, one cycle per word
//  mem_addr   out  ADDR_W  write address
//  mem_wdata  out  16      write data
//  start      out  1       run enable to the processor, held high while running
//  loading    out  1       image transfer in progress
//  err        out  1       sticky error flag
// BEHAVIOUR
//  Reset (async, active-low): all outputs 0; rx synchroniser flops = 1; both FSMs idle; word counter 0.
//  rx passes through a 2-flop synchroniser; all sampling uses the synchronised value.
//  Byte receiver:
//   R_IDLE: synced rx == 0 -> R_START, bit timer cleared.
//   R_START: after CLKS_PER_BIT/2 cycles, resample; 0 -> R_DATA; 1 -> R_IDLE (glitch, no byte).
//   R_DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first -> R_STOP.
//   R_STOP: sample after CLKS_PER_BIT; 1 -> 1-cycle byte_valid, R_IDLE; 0 -> framing error, R_IDLE.
//  Image format, big-endian: count_hi, count_lo (N words), then N x (word_hi, word_lo).
//  Loader FSM:
//   L_CNT_HI: byte -> latch count[15:8], loading=1 -> L_CNT_LO.
//   L_CNT_LO: byte -> count[7:0]; N==0 or N>MAX_WORDS -> L_ERR; else addr=0 -> L_DATA_HI.
//   L_DATA_HI: byte -> latch hi -> L_DATA_LO.
//   L_DATA_LO: byte -> next cycle mem_we=1, mem_addr=addr, mem_wdata={hi,lo}; addr+1;
//     last word (addr==N-1) -> L_RUN, else L_DATA_HI.
//   L_RUN: start=1 from cycle after last mem_we; loading=0; incoming bytes ignored.
//     hlt==1 -> start=0 next cycle -> L_CNT_HI (re-armed).
//   L_ERR: err=1, start=0, mem_we=0, loading=0; all bytes ignored; exit only by reset.
//  Framing error in any state except L_RUN -> L_ERR. Framing error in L_RUN ignored.
//  mem_addr, mem_wdata hold last written values between strobes.
//  Address never wraps: N<=MAX_WORDS guarantees addr <= MAX_WORDS-1.
//  Reset mid-transfer: immediate return to reset values. Partially written memory is not cleared.
//   The next image always starts at address 0.
//  hlt while not in L_RUN: ignored.
// TESTING (CLKS_PER_BIT=16)
//  1. Reset, send 00 02 12 34 AB CD -> mem_we at addr 0 data 0x1234, at addr 1 data 0xABCD;
//     start=1 one cycle after the second strobe; loading=0; err=0.
//  2. rx low for 4 cycles, then high -> no byte_valid, no state change, outputs unchanged.
//  3. Send 00 with stop bit 0 -> err=1, start=0. Then send a valid image -> no mem_we; err stays 1
//     until reset.
//  4. Send count 00 00 -> err=1. After reset, send count 20 01 (8193) -> err=1, no mem_we.
//  5. Load 00 01 55 AA -> start=1. Raise hlt -> start=0 next cycle.
//     Send 00 01 0F F0 -> write addr 0 data 0x0FF0, start=1 again.
//  6. Assert reset during the second data byte of word 1 -> all outputs 0 immediately.
//     After release, load 00 01 11 22 -> write at addr 0 data 0x1122, then start=1.

Source files
------------

// File: rtl/serial_program_loader.sv
// Boot loader: receives an 8N1 serial program image and writes it into instruction memory
// from address 0, then runs the processor until it halts and re-arms for the next image.
module serial_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned MAX_WORDS    = 8192
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              hlt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic              start_o,
    output logic              loading_o,
    output logic              err_o
);

    localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
    localparam logic [TimerW-1:0] HalfBit = TimerW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TimerW-1:0] FullBit = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
    typedef enum logic [2:0] {LCntHi, LCntLo, LDataHi, LDataLo, LRun, LErr} ld_state_e;

    logic              rx_meta_q, rx_sync_q;
    rx_state_e         rx_state_q;
    logic [TimerW-1:0] timer_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic              byte_valid_q, frame_err_q;

    ld_state_e         ld_state_q;
    logic [15:0]       count_q;
    logic [15:0]       addr_q;
    logic [7:0]        hi_q;
    logic              mem_we_q, start_q, loading_q, err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;

    logic [15:0]       new_count;
    logic              count_bad;
    logic              last_word;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Byte receiver: samples mid-bit, emits a one-cycle byte_valid or frame_err pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_q   <= RIdle;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (rx_state_q)
                RIdle: begin
                    if (!rx_sync_q) begin
                        rx_state_q <= RStart;
                        timer_q    <= '0;
                    end
                end
                RStart: begin
                    if (timer_q == HalfBit) begin
                        timer_q    <= '0;
                        bit_cnt_q  <= '0;
                        rx_state_q <= rx_sync_q ? RIdle : RData;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RData: begin
                    if (timer_q == FullBit) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RStop;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RStop: begin
                    if (timer_q == FullBit) begin
                        timer_q      <= '0;
                        rx_state_q   <= RIdle;
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= ~rx_sync_q;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: rx_state_q <= RIdle;
            endcase
        end
    end

    assign new_count = {count_q[15:8], shift_q};
    assign count_bad = (new_count == 16'd0) || ({16'd0, new_count} > 32'(MAX_WORDS));
    assign last_word = (addr_q == count_q - 16'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_state_q  <= LCntHi;
            count_q     <= '0;
            addr_q      <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            start_q     <= 1'b0;
            loading_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (frame_err_q && ld_state_q != LRun) begin
                ld_state_q <= LErr;
                err_q      <= 1'b1;
                start_q    <= 1'b0;
                loading_q  <= 1'b0;
            end else begin
                unique case (ld_state_q)
                    LCntHi: begin
                        if (byte_valid_q) begin
                            count_q[15:8] <= shift_q;
                            loading_q     <= 1'b1;
                            ld_state_q    <= LCntLo;
                        end
                    end
                    LCntLo: begin
                        if (byte_valid_q) begin
                            count_q[7:0] <= shift_q;
                            addr_q       <= '0;
                            if (count_bad) begin
                                ld_state_q <= LErr;
                                err_q      <= 1'b1;
                                loading_q  <= 1'b0;
                            end else begin
                                ld_state_q <= LDataHi;
                            end
                        end
                    end
                    LDataHi: begin
                        if (byte_valid_q) begin
                            hi_q       <= shift_q;
                            ld_state_q <= LDataLo;
                        end
                    end
                    LDataLo: begin
                        if (byte_valid_q) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_q[ADDR_W-1:0];
                            mem_wdata_q <= {hi_q, shift_q};
                            addr_q      <= addr_q + 16'd1;
                            if (last_word) begin
                                ld_state_q <= LRun;
                                loading_q  <= 1'b0;
                            end else begin
                                ld_state_q <= LDataHi;
                            end
                        end
                    end
                    LRun: begin
                        if (hlt_i) begin
                            start_q    <= 1'b0;
                            ld_state_q <= LCntHi;
                        end else begin
                            start_q <= 1'b1;
                        end
                    end
                    LErr: begin
                        err_q     <= 1'b1;
                        start_q   <= 1'b0;
                        loading_q <= 1'b0;
                    end
                    default: ld_state_q <= LErr;
                endcase
            end
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign start_o     = start_q;
    assign loading_o   = loading_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_serial_program_loader.sv
// Scoreboard bench: image bytes are parsed by a reference model into expected memory writes,
// a monitor pops and compares every write strobe and checks start timing.
module tb_serial_program_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        hlt = 1'b0;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        start, loading, err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_we_cyc = -100;
    logic start_prev = 1'b0;
    logic [28:0] exp_q[$];

    serial_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(13), .MAX_WORDS(8192)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_i       (rx),
        .hlt_i      (hlt),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .start_o    (start),
        .loading_o  (loading),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [28:0] e;
        cyc++;
        if (mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_we: addr %0h data %0h with nothing expected",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    bad++;
                    $display("FAIL mem_write: got addr %0h data %0h expected addr %0h data %0h",
                             mem_addr, mem_wdata, e[28:16], e[15:0]);
                end
            end
            last_we_cyc = cyc;
        end
        if (start === 1'b1 && start_prev !== 1'b1) begin
            total++;
            if (cyc - last_we_cyc != 1) begin
                bad++;
                $display("FAIL start_latency: got %0d cycles after last write expected 1",
                         cyc - last_we_cyc);
            end
        end
        start_prev = start;
    end

    // Reference model: parse an image into expected writes; returns whether it must error.
    task automatic model_image(input logic [7:0] b[$], output bit exp_err);
        int n;
        n = {b[0], b[1]};
        exp_err = (n == 0) || (n > 8192);
        if (!exp_err)
            for (int i = 0; i < n; i++) exp_q.push_back({13'(i), b[2 + 2 * i], b[3 + 2 * i]});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 + $urandom_range(0, 5)) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] b[$]);
        foreach (b[i]) send_byte(b[i], 1'b1);
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 400; i++) begin
            if (start === 1'b1) break;
            @(negedge clk);
        end
        check(name, 32'(start), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        rx = 1'b1;
        hlt = 1'b0;
        #1;
        check("reset_outputs", {mem_we, mem_addr, mem_wdata, start, loading, err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_hlt(input string name);
        @(negedge clk) hlt = 1'b1;
        @(negedge clk) hlt = 1'b0;
        check(name, 32'(start), 32'd0);
    endtask

    initial begin
        logic [7:0] img[$];
        bit e;
        int n;
        logic [15:0] w;

        // 1: basic two-word image
        do_reset();
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        model_image(img, e);
        send_bytes(img);
        wait_start("t1_start");
        check("t1_loading", 32'(loading), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_hold", {mem_addr, mem_wdata}, {13'd1, 16'hABCD});
        check("t1_queue", exp_q.size(), 0);
        pulse_hlt("t1_hlt_drop");

        // 2: short low glitch is not a byte
        @(negedge clk) rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t2_glitch", {start, loading, err}, 32'd0);

        // 5 + random: repeated load/halt cycles; hlt outside run is ignored
        img = '{8'h00, 8'h01, 8'h55, 8'hAA};
        model_image(img, e);
        send_bytes(img);
        wait_start("t5_start_a");
        pulse_hlt("t5_hlt_a");
        img = '{8'h00, 8'h01, 8'h0F, 8'hF0};
        model_image(img, e);
        send_bytes(img);
        wait_start("t5_start_b");
        check("t5_data", {mem_addr, mem_wdata}, {13'd0, 16'h0FF0});
        pulse_hlt("t5_hlt_b");
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, 4);
            img = '{8'h00, 8'(n)};
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom);
                img.push_back(w[15:8]);
                img.push_back(w[7:0]);
            end
            model_image(img, e);
            hlt = 1'($urandom_range(0, 1));
            for (int i = 0; i < img.size() - 1; i++) begin
                send_byte(img[i], 1'b1);
                if (i == 1) check("rnd_loading", 32'(loading), 32'd1);
            end
            hlt = 1'b0;
            send_byte(img[img.size() - 1], 1'b1);
            wait_start("rnd_start");
            check("rnd_queue", exp_q.size(), 0);
            repeat ($urandom_range(1, 20)) @(negedge clk);
            check("rnd_start_held", 32'(start), 32'd1);
            pulse_hlt("rnd_hlt");
        end

        // 3: framing error is sticky and blocks writes
        do_reset();
        send_byte(8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_err", {start, err}, 32'd1);
        send_bytes('{8'h00, 8'h01, 8'h12, 8'h34});
        repeat (40) @(negedge clk);
        check("t3_err_sticky", {start, loading, err}, 32'd1);

        // 4: count boundaries
        do_reset();
        send_bytes('{8'h00, 8'h00});
        repeat (4) @(negedge clk);
        check("t4_zero_count", 32'(err), 32'd1);
        do_reset();
        send_bytes('{8'h20, 8'h01, 8'h12, 8'h34});
        repeat (4) @(negedge clk);
        check("t4_over_count", {loading, err}, 32'd1);

        // 6: reset mid-transfer, then reload
        do_reset();
        exp_q.push_back({13'd0, 16'h1122});
        send_bytes('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33});
        @(negedge clk) rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        rx = 1'b1;
        do_reset();
        check("t6_queue", exp_q.size(), 0);
        img = '{8'h00, 8'h01, 8'h11, 8'h22};
        model_image(img, e);
        send_bytes(img);
        wait_start("t6_start");
        check("t6_data", {mem_addr, mem_wdata}, {13'd0, 16'h1122});

        repeat (10) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
